// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: tick-driven LED pattern sequencer with push-button mode selection.
// Optional macro LED_BTN_SYNC_EN inserts a 2-flop synchronizer on every button input.
module led_pattern_ctrl #(
   parameter int NB_LED = 4,
   parameter int NB_BTN = 4
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_tick,
   input  logic              i_run,
   input  logic              i_clear,
   input  logic [NB_BTN-1:0] i_btn,
   output logic [NB_LED-1:0] o_led,
   output logic [1:0]        o_mode,
   output logic [1:0]        o_state,
   output logic              o_step_done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HOLD = 2'd3
   } state_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   localparam logic [1:0] MODE_ROT_L    = 2'd0;
   localparam logic [1:0] MODE_ROT_R    = 2'd1;
   localparam logic [1:0] MODE_PINGPONG = 2'd2;
   localparam logic [1:0] MODE_FLASH    = 2'd3;

   state_t              state;
   dir_t                dir;
   logic [NB_LED-1:0]   led;
   logic [1:0]          mode;
   logic                step_done;
   logic                pending_valid;
   logic [1:0]          pending_mode;
   logic [NB_BTN-1:0]   btn_prev;
   logic [NB_BTN-1:0]   btn_in;
   logic [NB_BTN-1:0]   press;
   logic                press_any;
   logic [1:0]          press_mode;
   logic [NB_LED-1:0]   seed;
   logic [NB_LED-1:0]   adv_led;
   dir_t                adv_dir;

`ifdef LED_BTN_SYNC_EN
   logic [NB_BTN-1:0]   btn_meta;
   logic [NB_BTN-1:0]   btn_sync;

   always_ff @(posedge clock) begin
      if (i_reset) begin
         btn_meta <= '0;
         btn_sync <= '0;
      end else begin
         btn_meta <= i_btn;
         btn_sync <= btn_meta;
      end
   end

   assign btn_in = btn_sync;
`else
   assign btn_in = i_btn;
`endif

   // Rising-edge detect; scanning from the top down leaves the lowest pressed index.
   always_comb begin
      press      = btn_in & ~btn_prev;
      press_any  = 1'b0;
      press_mode = 2'd0;
      for (int k = NB_BTN - 1; k >= 0; k--) begin
         if (k < 4 && press[k]) begin
            press_any  = 1'b1;
            press_mode = 2'(k);
         end
      end
   end

   always_comb begin
      seed = '0;
      case (mode)
         MODE_ROT_L:    seed = NB_LED'(1);
         MODE_ROT_R:    seed = {1'b1, {(NB_LED-1){1'b0}}};
         MODE_PINGPONG: seed = NB_LED'(1);
         MODE_FLASH:    seed = '1;
         default:       seed = '0;
      endcase
   end

   // Ping-pong bounces off an end by reversing before the shift, so the end LED lights once.
   always_comb begin
      adv_led = led;
      adv_dir = dir;
      case (mode)
         MODE_ROT_L: adv_led = {led[NB_LED-2:0], led[NB_LED-1]};
         MODE_ROT_R: adv_led = {led[0], led[NB_LED-1:1]};
         MODE_PINGPONG: begin
            if (dir == DIR_LEFT && led[NB_LED-1]) begin
               adv_dir = DIR_RIGHT;
               adv_led = led >> 1;
            end else if (dir == DIR_RIGHT && led[0]) begin
               adv_dir = DIR_LEFT;
               adv_led = led << 1;
            end else if (dir == DIR_LEFT) begin
               adv_led = led << 1;
            end else begin
               adv_led = led >> 1;
            end
         end
         MODE_FLASH: adv_led = ~led;
         default:    adv_led = led;
      endcase
   end

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state         <= IDLE;
         dir           <= DIR_LEFT;
         led           <= '0;
         mode          <= MODE_ROT_L;
         step_done     <= 1'b0;
         pending_valid <= 1'b0;
         pending_mode  <= 2'd0;
         btn_prev      <= '0;
      end else begin
         btn_prev  <= btn_in;
         step_done <= 1'b0;
         if (i_clear) begin
            state         <= IDLE;
            led           <= '0;
            pending_valid <= 1'b0;
            dir           <= DIR_LEFT;
         end else begin
            case (state)
               IDLE: begin
                  led <= '0;
                  if (press_any) mode <= press_mode;
                  if (i_run) state <= LOAD;
               end
               LOAD: begin
                  led           <= seed;
                  dir           <= DIR_LEFT;
                  pending_valid <= press_any;
                  if (press_any) pending_mode <= press_mode;
                  state <= i_run ? RUN : HOLD;
               end
               RUN: begin
                  if (press_any) begin
                     pending_valid <= 1'b1;
                     pending_mode  <= press_mode;
                  end
                  if (!i_run) begin
                     state <= HOLD;
                  end else if (i_tick) begin
                     if (pending_valid) begin
                        mode  <= pending_mode;
                        state <= LOAD;
                     end else begin
                        led       <= adv_led;
                        dir       <= adv_dir;
                        step_done <= 1'b1;
                     end
                  end
               end
               HOLD: begin
                  if (press_any) begin
                     pending_valid <= 1'b1;
                     pending_mode  <= press_mode;
                  end
                  if (i_run) state <= RUN;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign o_led       = led;
   assign o_mode      = mode;
   assign o_state     = state;
   assign o_step_done = step_done;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed vector table plus hand sequences for led_pattern_ctrl
// (default build, buttons unsynchronized).
module tb_led_pattern_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   typedef struct {
      logic       run;
      logic       tick;
      logic       clear;
      logic [3:0] btn;
      logic [3:0] led;
      logic [1:0] mode;
      logic [1:0] state;
      logic       done;
   } vec_t;

   logic       clock;
   logic       i_reset;
   logic       i_tick;
   logic       i_run;
   logic       i_clear;
   logic [3:0] i_btn;
   logic [3:0] o_led;
   logic [1:0] o_mode;
   logic [1:0] o_state;
   logic       o_step_done;

   int   total_count;
   int   bad_count;
   vec_t vecs[$];

   led_pattern_ctrl #(
      .NB_LED(4),
      .NB_BTN(4)
   ) dut (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_tick      (i_tick),
      .i_run       (i_run),
      .i_clear     (i_clear),
      .i_btn       (i_btn),
      .o_led       (o_led),
      .o_mode      (o_mode),
      .o_state     (o_state),
      .o_step_done (o_step_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic applyStimulus(input logic run, input logic tick, input logic clear,
                                input logic [3:0] btn);
      i_run   = run;
      i_tick  = tick;
      i_clear = clear;
      i_btn   = btn;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic checkOutput(input string name, input logic [3:0] led, input logic [1:0] mode,
                              input logic [1:0] state, input logic done);
      total_count++;
      if (o_led !== led || o_mode !== mode || o_state !== state || o_step_done !== done) begin
         bad_count++;
         $display("[TB] FAIL %s: got led=%b mode=%0d state=%0d done=%b, want led=%b mode=%0d state=%0d done=%b",
                  name, o_led, o_mode, o_state, o_step_done, led, mode, state, done);
      end
   endtask

   task automatic addVec(input logic run, input logic tick, input logic clear, input logic [3:0] btn,
                         input logic [3:0] led, input logic [1:0] mode, input logic [1:0] state,
                         input logic done);
      vec_t v;
      v.run = run; v.tick = tick; v.clear = clear; v.btn = btn;
      v.led = led; v.mode = mode; v.state = state; v.done = done;
      vecs.push_back(v);
   endtask

   initial begin
      logic [3:0] exp_led;
      logic [1:0] exp_mode;
      logic [1:0] exp_state;
      logic       exp_done;
      logic       tick_now;

      total_count = 0;
      bad_count   = 0;

      // Plain rotate-left start-up, then mode 1, then ping-pong through both bounces.
      addVec(1, 0, 0, 4'b0000, 4'b0000, 2'd0, S_LOAD, 0);
      addVec(1, 0, 0, 4'b0000, 4'b0001, 2'd0, S_RUN,  0);
      addVec(1, 1, 0, 4'b0000, 4'b0010, 2'd0, S_RUN,  1);
      addVec(1, 0, 0, 4'b0000, 4'b0010, 2'd0, S_RUN,  0);
      addVec(1, 1, 0, 4'b0000, 4'b0100, 2'd0, S_RUN,  1);
      addVec(1, 1, 0, 4'b0000, 4'b1000, 2'd0, S_RUN,  1);
      addVec(1, 0, 0, 4'b0000, 4'b1000, 2'd0, S_RUN,  0);
      addVec(1, 1, 0, 4'b0000, 4'b0001, 2'd0, S_RUN,  1);
      addVec(1, 0, 0, 4'b0000, 4'b0001, 2'd0, S_RUN,  0);
      addVec(0, 0, 1, 4'b0000, 4'b0000, 2'd0, S_IDLE, 0);
      addVec(0, 0, 0, 4'b0010, 4'b0000, 2'd1, S_IDLE, 0);
      addVec(0, 0, 0, 4'b0000, 4'b0000, 2'd1, S_IDLE, 0);
      addVec(1, 0, 0, 4'b0000, 4'b0000, 2'd1, S_LOAD, 0);
      addVec(1, 0, 0, 4'b0000, 4'b1000, 2'd1, S_RUN,  0);
      addVec(1, 1, 0, 4'b0000, 4'b0100, 2'd1, S_RUN,  1);
      addVec(1, 1, 0, 4'b0000, 4'b0010, 2'd1, S_RUN,  1);
      addVec(0, 0, 1, 4'b0000, 4'b0000, 2'd1, S_IDLE, 0);
      addVec(0, 0, 0, 4'b0100, 4'b0000, 2'd2, S_IDLE, 0);
      addVec(0, 0, 0, 4'b0000, 4'b0000, 2'd2, S_IDLE, 0);
      addVec(1, 0, 0, 4'b0000, 4'b0000, 2'd2, S_LOAD, 0);
      addVec(1, 0, 0, 4'b0000, 4'b0001, 2'd2, S_RUN,  0);
      addVec(1, 1, 0, 4'b0000, 4'b0010, 2'd2, S_RUN,  1);
      addVec(1, 1, 0, 4'b0000, 4'b0100, 2'd2, S_RUN,  1);
      addVec(1, 1, 0, 4'b0000, 4'b1000, 2'd2, S_RUN,  1);
      addVec(1, 1, 0, 4'b0000, 4'b0100, 2'd2, S_RUN,  1);
      addVec(1, 1, 0, 4'b0000, 4'b0010, 2'd2, S_RUN,  1);
      addVec(1, 1, 0, 4'b0000, 4'b0001, 2'd2, S_RUN,  1);
      addVec(1, 1, 0, 4'b0000, 4'b0010, 2'd2, S_RUN,  1);

      i_reset = 1'b1;
      i_run   = 1'b0;
      i_tick  = 1'b0;
      i_clear = 1'b0;
      i_btn   = 4'b0000;
      repeat (3) @(negedge clock);
      i_reset = 1'b0;
      checkOutput("reset", 4'b0000, 2'd0, S_IDLE, 1'b0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].run, vecs[i].tick, vecs[i].clear, vecs[i].btn);
         checkOutput($sformatf("vec%0d", i), vecs[i].led, vecs[i].mode, vecs[i].state, vecs[i].done);
      end

      // Deferred mode change: press FLASH mid-step, no tick for 10 cycles, then the tick reloads.
      applyStimulus(0, 0, 1, 4'b0000);
      applyStimulus(0, 0, 0, 4'b0001);
      applyStimulus(0, 0, 0, 4'b0000);
      applyStimulus(1, 0, 0, 4'b0000);
      applyStimulus(1, 0, 0, 4'b0000);
      checkOutput("m0_seed", 4'b0001, 2'd0, S_RUN, 1'b0);
      applyStimulus(1, 1, 0, 4'b0000);
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("m0_at_0100", 4'b0100, 2'd0, S_RUN, 1'b1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 0, 0, 4'b1000);
         checkOutput($sformatf("defer_wait%0d", i), 4'b0100, 2'd0, S_RUN, 1'b0);
      end
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("defer_load", 4'b0100, 2'd3, S_LOAD, 1'b0);
      applyStimulus(1, 0, 0, 4'b0000);
      checkOutput("flash_seed", 4'b1111, 2'd3, S_RUN, 1'b0);
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("flash_off", 4'b0000, 2'd3, S_RUN, 1'b1);
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("flash_on", 4'b1111, 2'd3, S_RUN, 1'b1);

      // Pause wins over a same-cycle tick; ticks in HOLD do nothing.
      applyStimulus(0, 1, 0, 4'b0000);
      checkOutput("pause_tick", 4'b1111, 2'd3, S_HOLD, 1'b0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 1, 0, 4'b0000);
         checkOutput($sformatf("hold_tick%0d", i), 4'b1111, 2'd3, S_HOLD, 1'b0);
      end
      applyStimulus(1, 0, 0, 4'b0000);
      checkOutput("resume", 4'b1111, 2'd3, S_RUN, 1'b0);
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("resume_step", 4'b0000, 2'd3, S_RUN, 1'b1);

      // Simultaneous presses resolve to the lowest index, then clear mid-RUN.
      applyStimulus(1, 0, 0, 4'b0101);
      checkOutput("dual_press", 4'b0000, 2'd3, S_RUN, 1'b0);
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("dual_load", 4'b0000, 2'd0, S_LOAD, 1'b0);
      applyStimulus(1, 0, 0, 4'b0000);
      checkOutput("dual_seed", 4'b0001, 2'd0, S_RUN, 1'b0);
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("dual_step", 4'b0010, 2'd0, S_RUN, 1'b1);
      applyStimulus(1, 0, 0, 4'b1000);
      applyStimulus(1, 0, 1, 4'b0000);
      checkOutput("clear", 4'b0000, 2'd0, S_IDLE, 1'b0);
      applyStimulus(1, 0, 0, 4'b0000);
      checkOutput("clear_load", 4'b0000, 2'd0, S_LOAD, 1'b0);
      applyStimulus(1, 0, 0, 4'b0000);
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("clear_step", 4'b0010, 2'd0, S_RUN, 1'b1);

      // A button held for 20 cycles must register once: the second tick advances instead of reloading.
      exp_led   = 4'b0010;
      exp_mode  = 2'd0;
      exp_state = S_RUN;
      for (int i = 0; i < 20; i++) begin
         tick_now = (i == 5) || (i == 12);
         applyStimulus(1, tick_now, 0, 4'b0010);
         exp_done = 1'b0;
         if (i == 5) begin
            exp_mode  = 2'd1;
            exp_state = S_LOAD;
         end else if (i == 6) begin
            exp_led   = 4'b1000;
            exp_state = S_RUN;
         end else if (i == 12) begin
            exp_led  = 4'b0100;
            exp_done = 1'b1;
         end
         checkOutput($sformatf("held%0d", i), exp_led, exp_mode, exp_state, exp_done);
      end
      applyStimulus(1, 1, 0, 4'b0000);
      checkOutput("held_release", 4'b0010, 2'd1, S_RUN, 1'b1);

      $display("test done: total=%0d bad=%0d", total_count, bad_count);
      $finish;
   end

endmodule
